abox_inv_serial: RTL and testbench



---
 rtl/abox_inv_serial.sv | 125 ++++++++++++
 tb/tb_abox_inv_serial.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/abox_inv_serial.sv
// Masked inverse PRINCE affine nibble layer on a SHARES-way Boolean-shared 64-bit state, NIB_PER_CYC nibbles per cycle.
// Optional macro ABOX_INV_FWD_EN adds i_dir to select the forward map (i_dir=0) at run time.
module abox_inv_serial #(
   parameter int SHARES      = 5,
   parameter int NIB_PER_CYC = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [64*SHARES-1:0]  i_in_state,
`ifdef ABOX_INV_FWD_EN
   input  logic                  i_dir,
`endif
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [64*SHARES-1:0]  o_out_state,
   output logic                  o_busy
);

   localparam int W     = 64 * SHARES;
   localparam int STEPS = 16 / NIB_PER_CYC;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   if (SHARES < 1 || !(NIB_PER_CYC == 1 || NIB_PER_CYC == 2 || NIB_PER_CYC == 4 ||
                       NIB_PER_CYC == 8 || NIB_PER_CYC == 16)) begin : g_bad_param
      $error("abox_inv_serial: SHARES must be >= 1 and NIB_PER_CYC one of 1,2,4,8,16");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [W-1:0]    r_st;
   logic [W-1:0]    w_st_next;
   logic [CW-1:0]   r_cnt;
   logic            w_accept;
   logic            w_step;
   logic            w_last;
`ifdef ABOX_INV_FWD_EN
   logic            r_dir;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = S_BUSY;
         S_BUSY:  if (w_last) w_state_next = S_DONE;
         S_DONE:  if (i_out_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      o_in_ready  = (r_state == S_IDLE) && i_rst_n;
      o_out_valid = (r_state == S_DONE);
      o_busy      = (r_state != S_IDLE);
      o_out_state = (r_state == S_DONE) ? r_st : '0;
      w_accept    = o_in_ready && i_in_valid;
      w_step      = (r_state == S_BUSY);
      w_last      = w_step && (r_cnt == LAST);
   end

   // ---------------- shared state and nibble counter ----------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_st  <= '0;
         r_cnt <= '0;
`ifdef ABOX_INV_FWD_EN
         r_dir <= 1'b0;
`endif
      end else if (w_accept) begin
         r_st  <= i_in_state;
         r_cnt <= '0;
`ifdef ABOX_INV_FWD_EN
         r_dir <= i_dir;
`endif
      end else if (w_step) begin
         r_st  <= w_st_next;
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Per-nibble transform; the affine constant lands on share 0 only so every
   // other share sees just the linear part and shares never mix.
   genvar gs, gn;
   for (gs = 0; gs < SHARES; gs++) begin : g_share
      for (gn = 0; gn < 16; gn++) begin : g_nib
         localparam logic [CW-1:0] GRP   = CW'(gn / NIB_PER_CYC);
         localparam logic [3:0]    INV_K = (gs == 0) ? 4'b1011 : 4'b0000;
         logic [3:0] w_z;
         logic [3:0] w_inv;
         logic [3:0] w_nib;

         assign w_z   = r_st[64*gs + 4*gn +: 4];
         assign w_inv = {w_z[2], w_z[3], w_z[0], w_z[0] ^ w_z[1] ^ w_z[3]} ^ INV_K;
`ifdef ABOX_INV_FWD_EN
         localparam logic [3:0] FWD_K = (gs == 0) ? 4'b0101 : 4'b0000;
         logic [3:0] w_fwd;
         assign w_fwd = {w_z[2], w_z[3], w_z[0] ^ w_z[1] ^ w_z[2], w_z[1]} ^ FWD_K;
         assign w_nib = r_dir ? w_inv : w_fwd;
`else
         assign w_nib = w_inv;
`endif
         assign w_st_next[64*gs + 4*gn +: 4] = (r_cnt == GRP) ? w_nib : w_z;
      end
   end

endmodule

// File: tb/tb_abox_inv_serial.sv
// Randomized self-checking bench for abox_inv_serial against a cycle-level behavioural model.
module tb_abox_inv_serial;
   localparam int SHARES = 5;
   localparam int NPC    = 4;
   localparam int W      = 64 * SHARES;
   localparam int L      = 16 / NPC;
`ifdef ABOX_INV_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b0;
   logic          dir       = 1'b1;
   logic [W-1:0]  in_state  = '0;
   logic          o_in_ready;
   logic          o_out_valid;
   logic          o_busy;
   logic [W-1:0]  o_out_state;

   always #5 clk = ~clk;

   abox_inv_serial #(.SHARES(SHARES), .NIB_PER_CYC(NPC)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (o_in_ready),
      .i_in_state  (in_state),
`ifdef ABOX_INV_FWD_EN
      .i_dir       (dir),
`endif
      .o_out_valid (o_out_valid),
      .i_out_ready (out_ready),
      .o_out_state (o_out_state),
      .o_busy      (o_busy)
   );

   // Unmasked maps written straight from the nibble equations.
   function automatic logic [3:0] inv_nib(input logic [3:0] z);
      logic [3:0] x;
      x[0] = ~(z[0] ^ z[1] ^ z[3]);
      x[1] = ~z[0];
      x[2] = z[3];
      x[3] = ~z[2];
      return x;
   endfunction

   function automatic logic [3:0] fwd_nib(input logic [3:0] x);
      logic [3:0] z;
      z[0] = ~x[1];
      z[1] = x[0] ^ x[1] ^ x[2];
      z[2] = ~x[3];
      z[3] = x[2];
      return z;
   endfunction

   function automatic logic [3:0] amap(input logic [3:0] v, input logic d);
      if (FWD && !d) return fwd_nib(v);
      return inv_nib(v);
   endfunction

   // Affine f(v) = lin(v) ^ f(0): non-zero shares carry only lin(v) = f(v) ^ f(0).
   function automatic logic [W-1:0] model(input logic [W-1:0] st, input logic d);
      logic [W-1:0] r;
      logic [3:0]   zero4;
      zero4 = 4'h0;
      for (int s = 0; s < SHARES; s++)
         for (int n = 0; n < 16; n++)
            r[64*s + 4*n +: 4] = amap(st[64*s + 4*n +: 4], d) ^ ((s != 0) ? amap(zero4, d) : 4'h0);
      return r;
   endfunction

   function automatic logic [63:0] unmasked64(input logic [63:0] v, input logic d);
      logic [63:0] r;
      for (int n = 0; n < 16; n++) r[4*n +: 4] = amap(v[4*n +: 4], d);
      return r;
   endfunction

   function automatic logic [63:0] xor_shares(input logic [W-1:0] st);
      logic [63:0] r;
      r = '0;
      for (int s = 0; s < SHARES; s++) r ^= st[64*s +: 64];
      return r;
   endfunction

   // Behavioural model: 0 = idle, 1 = transforming (L cycles), 2 = result waiting.
   int           m_phase = 0;
   int           m_left  = 0;
   logic [W-1:0] m_res   = '0;
   logic [63:0]  m_xin   = '0;
   logic         m_dir   = 1'b1;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_res   <= '0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
                  m_phase <= 1;
                  m_left  <= L;
                  m_res   <= model(in_state, dir);
                  m_xin   <= xor_shares(in_state);
                  m_dir   <= dir;
               end
            1: begin
                  if (m_left == 1) m_phase <= 2;
                  m_left <= m_left - 1;
               end
            default: if (out_ready) m_phase <= 0;
         endcase
      end
   end

   int           n_checks = 0;
   int           n_errors = 0;
   logic         cmp_en   = 1'b0;
   logic         pin_en   = 1'b0;
   logic [W-1:0] pin_val  = '0;
   logic         ev;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (cmp_en) begin
         ev = (m_phase == 2);
         chk("out_valid", W'(o_out_valid), W'(ev));
         chk("in_ready", W'(o_in_ready), W'((m_phase == 0) && rst_n));
         chk("busy", W'(o_busy), W'(m_phase != 0));
         chk("out_state", o_out_state, ev ? m_res : '0);
         if (ev && o_out_valid) begin
            chk("xor_of_shares", W'(xor_shares(o_out_state)), W'(unmasked64(m_xin, m_dir)));
            if (pin_en) chk("literal", o_out_state, pin_val);
         end
      end
   end

   function automatic logic [W-1:0] rand_state();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Called at a negedge with the model idle; returns at the negedge after the handshake.
   task automatic send(input logic [W-1:0] st, input logic d, input int hold,
                       input logic pe, input logic [W-1:0] pv);
      pin_en    = pe;
      pin_val   = pv;
      in_state  = st;
      dir       = d;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 100 && m_phase != 2; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_state = rand_state();
         @(negedge clk);
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_state = rand_state();
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      pin_en    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] st;
      logic [W-1:0] pv;
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      st = '0; pv = '0; pv[63:0] = 64'hBBBB_BBBB_BBBB_BBBB;
      send(st, 1'b1, 0, 1'b1, pv);

      st = '0; st[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
      pv = '0; pv[63:0] = 64'h4444_4444_4444_4444;
      send(st, 1'b1, 0, 1'b1, pv);

      st = '0; st[63:0] = 64'h5555_5555_5555_5555;
      pv = '0;
      send(st, 1'b1, 1, 1'b1, pv);

      st = '0; st[127:0] = {2{64'hFFFF_FFFF_FFFF_FFFF}};
      pv = '0; pv[63:0] = 64'h4444_4444_4444_4444; pv[127:64] = 64'hFFFF_FFFF_FFFF_FFFF;
      send(st, 1'b1, 3, 1'b1, pv);

      // Reset while the counter sits at 2, then a clean transaction.
      in_state = rand_state();
      dir      = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      st = '0; pv = '0; pv[63:0] = 64'hBBBB_BBBB_BBBB_BBBB;
      send(st, 1'b1, 0, 1'b1, pv);

`ifdef ABOX_INV_FWD_EN
      st = '0; pv = '0; pv[63:0] = 64'h5555_5555_5555_5555;
      send(st, 1'b0, 0, 1'b1, pv);
`endif

      for (int t = 0; t < 40; t++) begin
         send(rand_state(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, '0);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
